// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter slice.
//   LAT_MAX_DEF    - default WAIT-cycle budget before an access is aborted
//   STARVE_MAX_DEF - default count of data grants allowed while fetch waits
//   arbState_t     - arbiter FSM states
//   owner_t        - which requester owns the current access
package mem_pkg;

  localparam int unsigned LAT_MAX_DEF    = 15;
  localparam int unsigned STARVE_MAX_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ERR
  } arbState_t;

  typedef enum logic {
    FETCH,
    DATA
  } owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Fetch starvation counter for the memory arbiter.
// Counts data grants made while a fetch request is waiting, saturating at
// STARVE_MAX; a fetch grant clears it.
//   clk, rst     - clock, synchronous active-high reset
//   dataGrant    - data requester granted this cycle
//   fetchGrant   - fetch requester granted this cycle
//   fetchWaiting - fetch request line is high
//   atMax        - counter has reached STARVE_MAX
module arb_starve_cnt
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic dataGrant,
  input  logic fetchGrant,
  input  logic fetchWaiting,
  output logic atMax
);

  localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CW-1:0] cnt;

  assign atMax = (cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (fetchGrant) begin
      cnt <= '0;
    end else if (dataGrant && fetchWaiting && !atMax) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: shares one backend port between an
// instruction-fetch read port and a data read/write port.
//   clk, rst                      - clock, synchronous active-high reset
//   if_req/if_addr                - fetch request and address (held until if_done)
//   if_done/if_rdata/if_stall     - fetch completion pulse, read data, stall
//   dm_req/dm_wr/dm_addr/dm_wdata - data request (held until dm_done)
//   dm_done/dm_err/dm_rdata/dm_stall - data completion, error flag, read data, stall
//   mem_en/mem_wr/mem_addr/mem_wdata - backend access strobe and payload
//   mem_stall/mem_done/mem_rdata  - backend back-pressure, completion, read data
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned LAT_MAX    = LAT_MAX_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic        dm_err,
  output logic        dm_stall,
  output logic [15:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned WCW = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  arbState_t   state, stateNext;
  owner_t      owner, ownerNext;
  logic [WCW-1:0] waitCnt;
  logic        ifPend, dmPend;
  logic        grantData, grantFetch;
  logic        starveAtMax;
  logic        timeout;
  logic [15:0] respData;

  // A request is ignored during its own done cycle, so a held line is only
  // re-granted from the following cycle.
  assign ifPend   = if_req & ~if_done;
  assign dmPend   = dm_req & ~dm_done;
  assign if_stall = ifPend;
  assign dm_stall = dmPend;

  assign timeout  = (state == WAIT) && !mem_done && (waitCnt == WCW'(LAT_MAX - 1));
  assign respData = (mem_done && !mem_wr) ? mem_rdata : '0;

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk         (clk),
    .rst         (rst),
    .dataGrant   (grantData),
    .fetchGrant  (grantFetch),
    .fetchWaiting(if_req),
    .atMax       (starveAtMax)
  );

  always_comb begin
    stateNext  = state;
    ownerNext  = owner;
    grantData  = 1'b0;
    grantFetch = 1'b0;
    case (state)
      IDLE: begin
        if (dmPend && !(ifPend && starveAtMax)) begin
          grantData = 1'b1;
          ownerNext = DATA;
          stateNext = dm_addr[0] ? ERR : ISSUE;
        end else if (ifPend) begin
          grantFetch = 1'b1;
          ownerNext  = FETCH;
          stateNext  = ISSUE;
        end
      end
      ISSUE:   if (!mem_stall) stateNext = WAIT;
      WAIT:    if (mem_done || timeout) stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= FETCH;
      waitCnt   <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      state   <= stateNext;
      owner   <= ownerNext;
      mem_en  <= (stateNext == ISSUE);
      if_done <= 1'b0;
      dm_done <= 1'b0;
      dm_err  <= 1'b0;

      if (grantData) begin
        mem_wr    <= dm_wr;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grantFetch) begin
        mem_wr    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end

      if (state == ISSUE) begin
        waitCnt <= '0;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt + 1'b1;
      end

      // respData is zero on timeout and for writes.
      if (state == WAIT && (mem_done || timeout)) begin
        if (owner == FETCH) begin
          if_done  <= 1'b1;
          if_rdata <= respData;
        end else begin
          dm_done  <= 1'b1;
          dm_err   <= !mem_done;
          dm_rdata <= respData;
        end
      end

      if (state == ERR) begin
        dm_done  <= 1'b1;
        dm_err   <= 1'b1;
        dm_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter. The reference model plans
// each granted access as a schedule (grant cycle, stall length, response
// delay) and derives expected strobes and done pulses by cycle arithmetic.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int LAT  = int'(LAT_MAX_DEF);
  localparam int SMAX = int'(STARVE_MAX_DEF);

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, ifDone, ifStall;
  logic [15:0] ifAddr, ifRdata;
  logic        dmReq, dmWr, dmDone, dmErr, dmStall;
  logic [15:0] dmAddr, dmWdata, dmRdata;
  logic        memEn, memWr, memStall, memDone;
  logic [15:0] memAddr, memWdata, memRdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .LAT_MAX   (LAT_MAX_DEF),
    .STARVE_MAX(STARVE_MAX_DEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (ifReq),
    .if_addr  (ifAddr),
    .if_done  (ifDone),
    .if_rdata (ifRdata),
    .if_stall (ifStall),
    .dm_req   (dmReq),
    .dm_wr    (dmWr),
    .dm_addr  (dmAddr),
    .dm_wdata (dmWdata),
    .dm_done  (dmDone),
    .dm_err   (dmErr),
    .dm_stall (dmStall),
    .dm_rdata (dmRdata),
    .mem_en   (memEn),
    .mem_wr   (memWr),
    .mem_addr (memAddr),
    .mem_wdata(memWdata),
    .mem_stall(memStall),
    .mem_done (memDone),
    .mem_rdata(memRdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Requester agents
  bit          fReq, dReq, dWrM;
  logic [15:0] fAddrM, dAddrM, dWdataM;
  int          fDoneAt = -10, dDoneAt = -10;
  int          reqPct, keepPct;

  // Planned access
  bit          busy = 0;
  bit          tData, tWr, tMis, tResp;
  logic [15:0] tAddr, tWdata, tRdata;
  int          tG, tStall, tRespAt, tDoneAt;
  int          starve = 0;

  task automatic newData();
    dReq    = 1'b1;
    dWrM    = 1'($urandom_range(1));
    dWdataM = 16'($urandom);
    dAddrM  = 16'($urandom);
    dAddrM[0] = ($urandom_range(4) == 0);
  endtask

  task automatic grant(input bit isData);
    int ws, delay;
    busy   = 1;
    tG     = cyc;
    tData  = isData;
    tWr    = isData ? dWrM : 1'b0;
    tAddr  = isData ? dAddrM : fAddrM;
    tWdata = dWdataM;
    tMis   = isData && dAddrM[0];
    tStall = ($urandom_range(99) < 60) ? 0 : int'($urandom_range(3));
    tResp  = ($urandom_range(9) != 0);
    delay  = ($urandom_range(99) < 70) ? int'($urandom_range(2)) : int'($urandom_range(LAT - 1));
    tRdata = 16'($urandom);
    ws      = tG + 2 + tStall;
    tRespAt = ws + delay;
    if (tMis)       tDoneAt = tG + 2;
    else if (tResp) tDoneAt = tRespAt + 1;
    else            tDoneAt = ws + LAT;
  endtask

  task automatic stepCycle(input bit doRst, input bit postRst);
    bit expEn, doneNow, expIf, expDm, fEff, dEff;

    // Agents: after a done pulse either re-request with new fields or drop.
    if (fReq && fDoneAt == cyc - 1) begin
      if ($urandom_range(99) < keepPct) fAddrM = 16'($urandom);
      else fReq = 0;
    end else if (!fReq && $urandom_range(99) < reqPct) begin
      fReq = 1; fAddrM = 16'($urandom);
    end
    if (dReq && dDoneAt == cyc - 1) begin
      if ($urandom_range(99) < keepPct) newData();
      else dReq = 0;
    end else if (!dReq && $urandom_range(99) < reqPct) begin
      newData();
    end

    // Backend: noise outside the planned windows, scheduled behaviour inside.
    memStall = ($urandom_range(3) == 0);
    memDone  = ($urandom_range(7) == 0);
    memRdata = 16'($urandom);
    if (busy && !tMis) begin
      if (cyc >= tG + 1 && cyc <= tG + 1 + tStall) memStall = (cyc <= tG + tStall);
      if (cyc >= tG + 2 + tStall && cyc < tDoneAt) begin
        memDone = tResp && (cyc == tRespAt);
        if (memDone) memRdata = tRdata;
      end
    end
    if (postRst) memDone = 1'b1;

    rst = doRst;
    ifReq = fReq; ifAddr = fAddrM;
    dmReq = dReq; dmWr = dWrM; dmAddr = dAddrM; dmWdata = dWdataM;
    #1;

    expEn   = busy && !tMis && cyc >= tG + 1 && cyc <= tG + 1 + tStall;
    doneNow = busy && cyc == tDoneAt;
    expIf   = doneNow && !tData;
    expDm   = doneNow && tData;

    checkVal("mem_en", 16'(memEn), 16'(expEn));
    if (expEn) begin
      checkVal("mem_addr", memAddr, tAddr);
      checkVal("mem_wr", 16'(memWr), 16'(tWr));
      if (tWr) checkVal("mem_wdata", memWdata, tWdata);
    end
    checkVal("if_done", 16'(ifDone), 16'(expIf));
    checkVal("dm_done", 16'(dmDone), 16'(expDm));
    checkVal("dm_err", 16'(dmErr), 16'(expDm && (tMis || !tResp)));
    if (expIf) checkVal("if_rdata", ifRdata, tResp ? tRdata : 16'h0000);
    if (expDm) checkVal("dm_rdata", dmRdata, (tMis || !tResp || tWr) ? 16'h0000 : tRdata);
    checkVal("if_stall", 16'(ifStall), 16'(fReq && !expIf));
    checkVal("dm_stall", 16'(dmStall), 16'(dReq && !expDm));
    if (postRst) begin
      checkVal("rst_mem_wr", 16'(memWr), 16'h0000);
      checkVal("rst_mem_addr", memAddr, 16'h0000);
      checkVal("rst_mem_wdata", memWdata, 16'h0000);
      checkVal("rst_if_rdata", ifRdata, 16'h0000);
      checkVal("rst_dm_rdata", dmRdata, 16'h0000);
    end

    if (doRst) begin
      busy = 0; starve = 0; fReq = 0; dReq = 0;
      fDoneAt = -10; dDoneAt = -10;
    end else begin
      if (doneNow) begin
        busy = 0;
        if (tData) dDoneAt = cyc; else fDoneAt = cyc;
      end
      if (!busy) begin
        fEff = fReq && (fDoneAt != cyc);
        dEff = dReq && (dDoneAt != cyc);
        if (dEff && !(fEff && starve == SMAX)) begin
          grant(1'b1);
          if (fReq && starve < SMAX) starve++;
        end else if (fEff) begin
          grant(1'b0);
          starve = 0;
        end
      end
    end
  endtask

  initial begin
    bit doRst, postRst;
    rst = 1'b1;
    ifReq = 0; ifAddr = '0; dmReq = 0; dmWr = 0; dmAddr = '0; dmWdata = '0;
    memStall = 0; memDone = 0; memRdata = '0;
    fReq = 0; dReq = 0; dWrM = 0; fAddrM = '0; dAddrM = '0; dWdataM = '0;
    repeat (2) @(posedge clk);
    #1;
    postRst = 1;
    for (int i = 0; i < 3000; i++) begin
      // Early phase: both requesters always busy to exercise starvation.
      reqPct  = (i < 400) ? 100 : 30;
      keepPct = (i < 400) ? 100 : 40;
      doRst   = (i >= 400) && ($urandom_range(149) == 0);
      stepCycle(doRst, postRst);
      postRst = doRst;
      @(posedge clk);
      #1;
      cyc++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT_MAX, default 15, is the number of WAIT cycles without mem_done after which the access is aborted.
REQ-002 Parameter STARVE_MAX, default 2, is the number of consecutive data grants allowed while fetch waits.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: if_req  input  1  fetch read request, held until if_done.
REQ-006 Port: if_addr  input  16  fetch address.
REQ-007 Port: if_done  output  1  one-cycle pulse, fetch read complete.
REQ-008 Port: if_rdata  output  16  fetch read data, valid with if_done.
REQ-009 Port: if_stall  output  1  fetch pending and not done this cycle.
REQ-010 Port: dm_req / dm_wr  input  1 / 1  data request, held until dm_done; dm_wr 1 means write.
REQ-011 Port: dm_addr / dm_wdata  input  16 / 16  data address and write data.
REQ-012 Port: dm_done / dm_err / dm_stall  output  1 / 1 / 1  done pulse; misaligned/timeout flag valid with dm_done; data pending and not done.
REQ-013 Port: dm_rdata  output  16  data read data, valid with dm_done.
REQ-014 Port: mem_en / mem_wr  output  1 / 1  backend access strobe and write select.
REQ-015 Port: mem_addr / mem_wdata  output  16 / 16  backend address and write data.
REQ-016 Port: mem_stall / mem_done  input  1 / 1  backend not accepting / access complete.
REQ-017 Port: mem_rdata  input  16  backend read data, valid with mem_done.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, ERR; state, the owner bit (FETCH/DATA) and all outputs except the two stall signals SHALL be registered.
REQ-019 IDLE: any request SHALL select an owner, latch its addr/wr/wdata, and enter ISSUE next cycle; otherwise remain in IDLE.
REQ-020 Priority: data wins a simultaneous request unless the starve counter equals STARVE_MAX, in which case fetch wins.
REQ-021 The starve counter SHALL increment on each data grant made while if_req=1, clear on each fetch grant, and saturate at STARVE_MAX.
REQ-022 ISSUE: mem_en=1 with latched signals; if mem_stall=1 remain in ISSUE; otherwise enter WAIT.
REQ-023 WAIT: mem_en=0; on mem_done the owner's done SHALL pulse for exactly one cycle with rdata=mem_rdata for reads and 0x0000 for writes; the FSM SHALL return to IDLE.
REQ-024 A WAIT lasting LAT_MAX cycles with no mem_done SHALL end in a dm_done pulse with dm_err=1 for a data owner, or an if_done pulse with if_rdata=0x0000 for a fetch owner; the FSM SHALL then return to IDLE.
REQ-025 A data request with dm_addr[0]=1 SHALL enter ERR instead of ISSUE, generate no backend access, pulse dm_done with dm_err=1 and dm_rdata=0x0000, and return to IDLE.
REQ-026 Minimum latency SHALL be 3 cycles from request (IDLE) to done pulse, with a backend mem_done in the cycle after ISSUE.
REQ-027 if_stall SHALL equal if_req & ~if_done, and dm_stall SHALL equal dm_req & ~dm_done, both combinational.
REQ-028 A request still high in the cycle after its done pulse SHALL be treated as a new request.
REQ-029 mem_done outside WAIT SHALL be ignored.

Reset
REQ-030 rst=1 SHALL force IDLE, owner FETCH, starve counter 0, and mem_en, mem_wr, if_done, dm_done and dm_err to 0.
REQ-031 rst=1 SHALL force mem_addr, mem_wdata, if_rdata and dm_rdata to 0x0000.
REQ-032 Reset mid-access SHALL abort without any done pulse; a later mem_done SHALL be ignored.

Structure
REQ-033 The state encoding, owner enum and default LAT_MAX/STARVE_MAX constants SHALL reside in shared package mem_pkg.
REQ-034 The starve counter SHALL be sub-module arb_starve_cnt; all else inline.

Verification
REQ-035 if_req alone, addr 0x0010, mem_done one cycle after ISSUE, mem_rdata 0xBEEF -> if_done on cycle 3 with if_rdata 0xBEEF, exactly one mem_en.
REQ-036 dm_req write 0x0020/0x1234 together with if_req -> data served first (mem_wr=1, dm_rdata 0x0000), then fetch.
REQ-037 dm_req held continuously with if_req -> grant order D,D,F,D,D,F.
REQ-038 dm_addr 0x0021 -> dm_done with dm_err=1 after 2 cycles, mem_en never asserted.
REQ-039 mem_stall held 3 cycles in ISSUE -> mem_en high 4 cycles, one done pulse; no mem_done for 15 WAIT cycles -> dm_err=1.
REQ-040 rst pulsed during WAIT, then mem_done -> no done pulse, FSM in IDLE, all outputs at reset values.
